// File: rtl/rob_commit.sv
// rob_commit: in-order commit stage of a reorder buffer.
//
// Entries are allocated at the tail by dispatch, marked done by a completion
// broadcast, and retired in order from the head. A retirement produces one
// registered register-file write on the following cycle. A flush walks every
// in-flight entry from head to tail, one per cycle, and emits a restore write
// for each destination instead of a commit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_en, alloc_dest     dispatch request and its destination register
//   alloc_ready, alloc_id    allocation possible this cycle / tail index
//   done_en, done_id,
//   done_data                completion broadcast
//   flush                    discard all in-flight entries
//   write_en, write_addr,
//   write_restore,
//   write_is_ref, write_data registered register-file write port
//   busy                     flush walk in progress
module rob_commit #(
    parameter int ROB_DEPTH      = 16,
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_en,
    input  logic [4:0]                alloc_dest,
    output logic                      alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
    input  logic                      done_en,
    input  logic [ROB_ADDR_WIDTH-1:0] done_id,
    input  logic [31:0]               done_data,
    input  logic                      flush,
    output logic                      write_en,
    output logic [4:0]                write_addr,
    output logic                      write_restore,
    output logic                      write_is_ref,
    output logic [31:0]               write_data,
    output logic                      busy
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [ROB_ADDR_WIDTH:0] DEPTH_C = (ROB_ADDR_WIDTH+1)'(ROB_DEPTH);

    state_t                    state;
    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;
    logic [4:0]                dest_q [ROB_DEPTH];
    logic [31:0]               data_q [ROB_DEPTH];
    logic [ROB_ADDR_WIDTH-1:0] head;
    logic [ROB_ADDR_WIDTH-1:0] tail;
    logic [ROB_ADDR_WIDTH:0]   count;

    logic flush_start;
    logic do_alloc;
    logic do_done;
    logic do_retire;

    assign alloc_ready  = (state == RUN) && (count < DEPTH_C);
    assign alloc_id     = tail;
    assign busy         = (state == FLUSH);
    assign write_is_ref = 1'b0;

    // A flush that starts this cycle suppresses every other RUN action.
    always_comb begin
        flush_start = (state == RUN) && flush && (count != '0);
        do_alloc    = alloc_en && alloc_ready && !flush_start;
        // The freshly allocated tail entry is never completed in its own cycle.
        do_done     = (state == RUN) && !flush_start && done_en && valid_q[done_id]
                      && !(do_alloc && (done_id == tail));
        // Retirement uses the pre-edge done flag, giving a two-cycle commit latency.
        do_retire   = (state == RUN) && !flush_start && valid_q[head] && done_q[head];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            valid_q       <= '0;
            done_q        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            write_en      <= 1'b0;
            write_restore <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;
        end else begin
            write_en      <= 1'b0;
            write_restore <= 1'b0;
            write_addr    <= '0;
            write_data    <= '0;

            case (state)
                RUN: begin
                    if (flush_start) begin
                        state <= FLUSH;
                    end else begin
                        if (do_alloc) begin
                            valid_q[tail] <= 1'b1;
                            done_q[tail]  <= 1'b0;
                            dest_q[tail]  <= alloc_dest;
                            tail          <= tail + 1'b1;
                        end
                        if (do_done) begin
                            done_q[done_id] <= 1'b1;
                            data_q[done_id] <= done_data;
                        end
                        // Placed after the completion update so a late done_en
                        // aimed at the retiring head cannot resurrect it.
                        if (do_retire) begin
                            valid_q[head] <= 1'b0;
                            done_q[head]  <= 1'b0;
                            head          <= head + 1'b1;
                            write_en      <= (dest_q[head] != 5'd0);
                            write_addr    <= dest_q[head];
                            write_data    <= data_q[head];
                        end
                        if (do_alloc && !do_retire) begin
                            count <= count + 1'b1;
                        end else if (!do_alloc && do_retire) begin
                            count <= count - 1'b1;
                        end
                    end
                end

                FLUSH: begin
                    valid_q[head] <= 1'b0;
                    done_q[head]  <= 1'b0;
                    head          <= head + 1'b1;
                    count         <= count - 1'b1;
                    write_en      <= (dest_q[head] != 5'd0);
                    write_restore <= 1'b1;
                    write_addr    <= dest_q[head];
                    if (count == (ROB_ADDR_WIDTH+1)'(1)) begin
                        state <= RUN;
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL provide parameter ROB_DEPTH, default 16: number of reorder-buffer entries, power of two.
REQ-002 SHALL provide parameter ROB_ADDR_WIDTH, default 4: width of entry ids, log2(ROB_DEPTH).
REQ-003 SHALL provide the following ports, clock and reset first:
  clk  in  1  sole clock; all state updates on its rising edge
  rst  in  1  synchronous, active-high reset
  alloc_en  in  1  dispatch requests one entry
  alloc_dest  in  5  destination register of the dispatched instruction
  alloc_ready  out  1  an entry can be allocated this cycle
  alloc_id  out  ROB_ADDR_WIDTH  id the next allocation receives (tail index)
  done_en  in  1  completion broadcast valid
  done_id  in  ROB_ADDR_WIDTH  entry being completed
  done_data  in  32  result value
  flush  in  1  discard all in-flight entries
  write_en  out  1  register file write strobe
  write_addr  out  5  register file write address
  write_restore  out  1  clear the reference bit of write_addr
  write_is_ref  out  1  always 0 from this block
  write_data  out  32  committed value
  busy  out  1  flush walk in progress

Function
REQ-004 SHALL hold per entry: valid, done, dest[4:0], data[31:0]; SHALL keep head, tail (ROB_ADDR_WIDTH, wrap modulo ROB_DEPTH) and count (0..ROB_DEPTH).
REQ-005 SHALL have states RUN and FLUSH.
REQ-006 alloc_ready SHALL be 1 iff state is RUN and count < ROB_DEPTH; alloc_id SHALL equal tail combinationally.
REQ-007 In RUN, alloc_en with alloc_ready SHALL write entry[tail] with valid=1, done=0, dest=alloc_dest, then tail+1 and count+1.
REQ-008 alloc_en without alloc_ready SHALL be ignored, with no state change.
REQ-009 In RUN, done_en SHALL set done=1 and data=done_data on entry[done_id] only if that entry is already valid; otherwise it SHALL be ignored.
REQ-010 done_en targeting the entry allocated in the same cycle SHALL be ignored.
REQ-011 In RUN, if entry[head] is valid and done at a rising edge, the block SHALL retire it: clear valid, head+1, count-1.
REQ-012 A retirement SHALL, on the next cycle, drive write_en=(dest!=0), write_addr=dest, write_data=data, write_restore=0.
REQ-013 Outputs SHALL be registered, so commit latency from done_en to write_en is 2 cycles: done flag is captured at edge N, retirement at edge N+1, write visible after edge N+1.
REQ-014 At most one retirement SHALL occur per cycle.
REQ-015 Simultaneous allocation and retirement SHALL leave count unchanged.
REQ-016 A full buffer with a simultaneous retirement SHALL still refuse allocation that cycle, since alloc_ready is based on the pre-edge count.
REQ-017 flush in RUN with count>0 SHALL enter FLUSH at the edge; in that cycle no allocation, completion or retirement SHALL take effect.
REQ-018 flush in RUN with count==0 SHALL have no effect.
REQ-019 In FLUSH, each cycle the block SHALL clear entry[head], advance head and decrement count.
REQ-020 In FLUSH, each step SHALL drive next cycle write_en=(dest!=0), write_restore=1, write_addr=dest, write_data=0, regardless of that entry's done bit.
REQ-021 FLUSH SHALL return to RUN at the edge where count reaches 0, leaving head==tail.
REQ-022 In FLUSH, alloc_en, done_en and flush SHALL be ignored; busy SHALL be 1 iff state is FLUSH.
REQ-023 When no commit or restore step occurred at the previous edge, write_en and write_restore SHALL be 0 and write_addr and write_data SHALL be 0.

Reset
REQ-024 rst=1 at a rising edge SHALL set head=tail=count=0, clear all valid and done bits, state=RUN, and all registered outputs to 0.
REQ-025 After reset, alloc_ready=1, alloc_id=0 and busy=0.
REQ-026 Reset SHALL take priority over every other input, including mid-FLUSH, which aborts with no further restore writes.

Verification
REQ-027 Basic commit: after reset, alloc dest=5, then done id=0 data=0xDEADBEEF -> two cycles later exactly one cycle of write_en=1, addr=5, data=0xDEADBEEF, restore=0.
REQ-028 In-order retirement: alloc dests 1,2,3; complete ids 2,1,0 in successive cycles -> writes to regs 1,2,3 on consecutive cycles, in that order.
REQ-029 Full and wrap-around: 16 allocations -> alloc_ready=0 and a 17th alloc_en is ignored; retire one entry, allocate again -> alloc_id=0 and count=16.
REQ-030 Flush walk: 3 pending entries with dests 4,0,7 (one of them done), then flush -> busy for 3 cycles, restore writes to 4 and 7 only (write_en=0 for dest 0), then alloc_ready=1 with head==tail.
REQ-031 Corner cases: done_en for an invalid id -> no effect; alloc of dest 0 completed -> retires with write_en=0; rst asserted mid-FLUSH -> all outputs 0 on the next cycle.
